proc_sequencer: RTL and testbench
=================================

Name: proc_sequencer

Overview:
- Instruction sequencer that runs the 9-bit proc3 processor from a synchronous program ROM.
- Fetches each instruction word, presents it on the processor's DIN with a one-cycle Run pulse, and supplies the mvi immediate word in the following cycle.
- Waits for Done, then advances the PC.
- Sits between the program ROM and the processor; shares Clock and Resetn with both.

Parameters:
- AW, 5: ROM address / PC width.
- PROG_LEN, 32: number of valid program words; must be ≤ 2^AW.
- WAIT_MAX, 4: cycles allowed in EXEC without Done before a timeout error.

Ports:
- Clock  in  1  system clock, rising edge.
- Resetn  in  1  synchronous, active-low reset.
- Start  in  1  begin or restart the program at address 0; sampled only in IDLE/HALT.
- MemAddr  out  AW  ROM address; MemQ is valid the cycle after.
- MemQ  in  9  ROM read data.
- DIN  out  9  processor data input.
- Run  out  1  processor Run.
- Done  in  1  processor Done.
- Pc  out  AW  current PC.
- Busy  out  1  high in FETCH/ISSUE/EXEC.
- Halted  out  1  high in HALT.
- Err  out  1  sticky error flag (timeout or truncated mvi).
- InstrCount  out  8  completed instructions, saturating at 255.

Behaviour:
- Reset (Resetn low at posedge): state=IDLE, Pc=0, Run=0, DIN=0, Busy=0, Halted=0, Err=0, InstrCount=0. Reset mid-instruction abandons it. The processor shares Resetn, so both restart together.
- Opcode = word[8:6]: 000 mv, 001 mvi, 010 add, 011 sub, 111 HALT. 100–110 issue as no-op words; the processor is expected to return to T0 with no Done, which hits the timeout.
- IDLE:
  - Start → Pc=0, InstrCount=0, Err=0, go to FETCH.
- FETCH:
  - MemAddr=Pc, Run=0.
  - If Pc==PROG_LEN → HALT; else → ISSUE.
- ISSUE (MemQ = instruction):
  - If opcode==111 → HALT, no Run.
  - If opcode==mvi and Pc+1==PROG_LEN → Err=1, HALT, no Run.
  - Otherwise: DIN=MemQ, Run=1 for exactly this cycle, MemAddr=Pc+1, Pc<=Pc+1, latch opcode, clear the watchdog, go to EXEC.
- EXEC:
  - Run=0, MemAddr=Pc, DIN=MemQ. The first EXEC cycle carries the immediate for mvi.
  - Done is expected in EXEC cycle 1 for mv/mvi and cycle 3 for add/sub.
  - On Done: InstrCount+1 (saturating). If the opcode was mvi, Pc<=Pc+1. Go to FETCH.
  - Watchdog counts EXEC cycles; reaching WAIT_MAX without Done → Err=1, HALT.
- HALT:
  - Run=0, Halted=1.
  - Start → same actions as Start in IDLE.
- Start while Busy is ignored.
- Done outside EXEC is ignored.
- Done in the same cycle the watchdog expires: Done wins.
- DIN=0 in IDLE/HALT/FETCH.
- Per-instruction throughput: mv/mvi 3 cycles (FETCH, ISSUE, EXEC); add/sub 5 cycles.
- Pc never wraps, because PROG_LEN bounds it.

Optional Feature:
- Macro: PROC_SEQ_SINGLE_STEP_EN.
- Defined:
  - Adds input Step (1 bit).
  - After each Done, the FSM enters a PAUSE state: Busy=0, Run=0, Pc is held.
  - A Step pulse → FETCH.
  - Start in PAUSE restarts from 0.
- Undefined: no Step port, no PAUSE state; the FSM goes straight from EXEC to FETCH.

Decomposition:
- Package proc_seq_pkg:
  - State enum: IDLE, FETCH, ISSUE, EXEC, HALT, PAUSE.
  - Opcode constants: OP_MV=000, OP_MVI=001, OP_ADD=010, OP_SUB=011, OP_HALT=111.
  - WORD_W=9.
- Sub-module seq_watchdog: loadable down-counter with clear, enable and expire output. Everything else stays in proc_sequencer.

Test Plan:
- Program {mvi R0,#5 (001000000 / 000000101); HALT 111000000}, Start pulse:
  - Run high 1 cycle with DIN=9'o100; next cycle DIN=5 and Done.
  - Then Pc=2 → HALT, Halted=1, InstrCount=1.
- Program {mv R1,R0; add R0,R1; sub R0,R1; HALT}:
  - Run pulses spaced 3 cycles (mv) then 5 cycles (add, sub).
  - InstrCount=3, final Pc=3, Err=0.
- Done tied low after the Run of an add: Err=1 and Halted=1 after exactly WAIT_MAX=4 EXEC cycles, with no further Run.
- PROG_LEN=2, program {mv, mvi at address 1}: mvi is not issued, Err=1, HALT; the Run count is 1.
- Resetn low for 1 cycle during EXEC of add: next cycle all outputs are at reset values and state is IDLE; Start then reruns from Pc=0.
- PROC_SEQ_SINGLE_STEP_EN defined, 2-instruction program:
  - Pauses after each Done (Busy=0); each Step pulse issues exactly one Run.
  - Start pulsed while Busy has no effect.

Source files
------------

// File: rtl/proc_seq_pkg.sv
// proc_seq_pkg: shared states, opcodes and word width for the proc3 sequencer
package proc_seq_pkg;
  localparam int WORD_W = 9;
  typedef enum logic [2:0] {IDLE, FETCH, ISSUE, EXEC, HALT, PAUSE} state_e;
  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_HALT = 3'b111;
endpackage

// File: rtl/seq_watchdog.sv
// seq_watchdog: loadable down-counter that flags expiry while enabled and at zero
module seq_watchdog #(
  parameter int W = 3
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         expire_o
);
  logic [W-1:0] cnt_q, cnt_d;
  assign expire_o = en_i && cnt_q == '0;
  // reload on request, otherwise count down while enabled and stop at zero
  always_comb cnt_d = load_i ? load_val_i : (en_i && cnt_q != '0) ? cnt_q - W'(1) : cnt_q;
  // counter register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end
endmodule

// File: rtl/proc_sequencer.sv
// proc_sequencer: fetch/issue/exec sequencer driving proc3 from a synchronous ROM; PROC_SEQ_SINGLE_STEP_EN adds Step and a PAUSE state
module proc_sequencer
  import proc_seq_pkg::*;
#(
  parameter int AW       = 5,
  parameter int PROG_LEN = 32,
  parameter int WAIT_MAX = 4
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              Start,
  output logic [AW-1:0]     MemAddr,
  input  logic [WORD_W-1:0] MemQ,
  output logic [WORD_W-1:0] DIN,
  output logic              Run,
  input  logic              Done,
  output logic [AW-1:0]     Pc,
  output logic              Busy,
  output logic              Halted,
  output logic              Err,
  output logic [7:0]        InstrCount
`ifdef PROC_SEQ_SINGLE_STEP_EN
  ,
  input  logic              Step
`endif
);
  localparam int WW = $clog2(WAIT_MAX + 1);
  // one extra PC bit so that PC can reach PROG_LEN when it equals 2^AW
  localparam logic [AW:0] LEN = (AW+1)'(PROG_LEN);
  state_e      state_q, state_d;
  logic [AW:0] pc_q, pc_d, pc_inc;
  logic [2:0]  op_q, op_d, mem_op;
  logic [7:0]  cnt_q, cnt_d;
  logic        err_q, err_d, issue_ok, expire;
  assign pc_inc   = pc_q + (AW+1)'(1);
  assign mem_op   = MemQ[8:6];
  assign issue_ok = state_q == ISSUE && mem_op != OP_HALT && !(mem_op == OP_MVI && pc_inc == LEN);
  assign Run        = issue_ok;
  assign DIN        = (issue_ok || state_q == EXEC) ? MemQ : '0;
  assign MemAddr    = state_q == ISSUE ? pc_inc[AW-1:0] : pc_q[AW-1:0];
  assign Pc         = pc_q[AW-1:0];
  assign Busy       = state_q inside {FETCH, ISSUE, EXEC};
  assign Halted     = state_q == HALT;
  assign Err        = err_q;
  assign InstrCount = cnt_q;
  seq_watchdog #(.W(WW)) u_wd (
    .clk_i      (Clock),
    .rst_ni     (Resetn),
    .load_i     (issue_ok),
    .load_val_i (WW'(WAIT_MAX - 1)),
    .en_i       (state_q == EXEC),
    .expire_o   (expire)
  );
  // next state: instruction walk, with Start from any non-busy state restarting at address 0
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    op_d    = op_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      FETCH: state_d = pc_q == LEN ? HALT : ISSUE;
      ISSUE: begin
        if (issue_ok) begin
          pc_d    = pc_inc;
          op_d    = mem_op;
          state_d = EXEC;
        end else begin
          err_d   = err_q | (mem_op != OP_HALT);
          state_d = HALT;
        end
      end
      EXEC: begin
        if (Done) begin
          cnt_d   = cnt_q + {7'd0, cnt_q != 8'hff};
          pc_d    = op_q == OP_MVI ? pc_inc : pc_q;
`ifdef PROC_SEQ_SINGLE_STEP_EN
          state_d = PAUSE;
`else
          state_d = FETCH;
`endif
        end else if (expire) begin
          err_d   = 1'b1;
          state_d = HALT;
        end
      end
`ifdef PROC_SEQ_SINGLE_STEP_EN
      PAUSE: state_d = Step ? FETCH : PAUSE;
`endif
      default: ;
    endcase
    if (Start && !Busy) begin
      pc_d    = '0;
      cnt_d   = '0;
      err_d   = 1'b0;
      state_d = FETCH;
    end
  end
  // state registers
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_q <= IDLE;
      pc_q    <= '0;
      op_q    <= OP_MV;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      op_q    <= op_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_proc_sequencer.sv
// tb_proc_sequencer: directed programs checked cycle by cycle against an instruction-walk model
module tb_proc_sequencer;
  import proc_seq_pkg::*;
  localparam int AW = 5, PL = 32, WM = 4;
`ifdef PROC_SEQ_SINGLE_STEP_EN
  localparam int SP = 1;
  logic Step = 1'b1;
`else
  localparam int SP = 0;
`endif
  typedef struct packed {
    logic run; logic [8:0] din; logic [4:0] pc; logic [4:0] ma;
    logic busy; logic halt; logic err; logic [7:0] cnt;
  } exp_t;

  logic Clock = 1'b0, Resetn = 1'b0, Start = 1'b0, Done;
  logic Run, Busy, Halted, Err;
  logic [AW-1:0] MemAddr, Pc;
  logic [8:0] MemQ, DIN;
  logic [7:0] InstrCount;
  logic [8:0] rom [32];
  logic Start2 = 1'b0, Done2, Run2, Busy2, Halted2, Err2;
  logic [AW-1:0] MemAddr2, Pc2;
  logic [8:0] MemQ2, DIN2;
  logic [7:0] InstrCount2;
  logic [8:0] rom2 [32];

  int checks = 0, errors = 0, cyc = 0, runs = 0, runs2 = 0;
  int ex_n = -1, d2 = -1, lat = 0, extra = 0;
  logic [2:0] ex_op = OP_MV;
  logic kill = 1'b0, stray = 1'b0;
  int run_cyc [64];
  logic [8:0] run_din [64];
  logic [8:0] nxt_din = '0;
  logic prev_run = 1'b0;
  exp_t q [$];
  exp_t ce, ca;

  always #5 Clock = ~Clock;

  proc_sequencer dut (
    .Clock(Clock), .Resetn(Resetn), .Start(Start), .MemAddr(MemAddr), .MemQ(MemQ),
    .DIN(DIN), .Run(Run), .Done(Done), .Pc(Pc), .Busy(Busy), .Halted(Halted),
    .Err(Err), .InstrCount(InstrCount)
`ifdef PROC_SEQ_SINGLE_STEP_EN
    , .Step(Step)
`endif
  );

  proc_sequencer #(.PROG_LEN(2)) dut2 (
    .Clock(Clock), .Resetn(Resetn), .Start(Start2), .MemAddr(MemAddr2), .MemQ(MemQ2),
    .DIN(DIN2), .Run(Run2), .Done(Done2), .Pc(Pc2), .Busy(Busy2), .Halted(Halted2),
    .Err(Err2), .InstrCount(InstrCount2)
`ifdef PROC_SEQ_SINGLE_STEP_EN
    , .Step(1'b1)
`endif
  );

  always @(posedge Clock) MemQ <= rom[MemAddr];
  always @(posedge Clock) MemQ2 <= rom2[MemAddr2];

  // processor stand-in: ex_n counts EXEC cycles after the Run cycle
  always @(negedge Clock) begin
    if (!Resetn) ex_n <= -1;
    else if (Run) begin ex_n <= 0; ex_op <= DIN[8:6]; end
    else if (ex_n >= 0) ex_n <= ex_n + 1;
    if (!Resetn) d2 <= -1;
    else if (Run2) d2 <= 0;
    else if (d2 >= 0) d2 <= d2 + 1;
  end
  always_comb begin
    lat = (ex_op == OP_MV || ex_op == OP_MVI) ? 1 : (ex_op == OP_ADD || ex_op == OP_SUB) ? 3 + extra : 0;
    Done = (!kill && lat != 0 && ex_n == lat) || stray;
    Done2 = d2 == 1;
  end

  // Run monitor
  always @(negedge Clock) begin
    cyc <= cyc + 1;
    if (Run) begin run_cyc[runs % 64] <= cyc; run_din[runs % 64] <= DIN; runs <= runs + 1; end
    if (Run2) runs2 <= runs2 + 1;
    if (prev_run) nxt_din <= DIN;
    prev_run <= Run;
  end

  // per-cycle compare against the model queue
  always @(negedge Clock) begin
    if (q.size() != 0) begin
      ce = q.pop_front();
      ca = '{Run, DIN, Pc, MemAddr, Busy, Halted, Err, InstrCount};
      checks++;
      if (ca !== ce) begin
        errors++;
        $display("FAIL cycle %0d: got run=%b din=%o pc=%0d addr=%0d busy=%b halted=%b err=%b count=%0d want run=%b din=%o pc=%0d addr=%0d busy=%b halted=%b err=%b count=%0d",
          cyc, ca.run, ca.din, ca.pc, ca.ma, ca.busy, ca.halt, ca.err, ca.cnt,
          ce.run, ce.din, ce.pc, ce.ma, ce.busy, ce.halt, ce.err, ce.cnt);
      end
    end
  end

  function automatic exp_t mk(input bit r, input logic [8:0] d, input int p, input int m,
                              input bit b, input bit h, input bit e, input int c);
    exp_t x;
    x.run = r; x.din = d; x.pc = 5'(p); x.ma = 5'(m);
    x.busy = b; x.halt = h; x.err = e; x.cnt = 8'(c);
    return x;
  endfunction

  // walk the program: FETCH, ISSUE, EXEC cycles per instruction, then a few HALT cycles
  task automatic gen(input int ext, input bit kl);
    int pc = 0, cnt = 0, l;
    bit err = 0, fin = 0;
    logic [8:0] w;
    logic [2:0] op;
    while (!fin) begin
      q.push_back(mk(0, 0, pc, pc, 1, 0, err, cnt));
      if (pc == PL) break;
      w = rom[pc % 32];
      op = w[8:6];
      if (op == OP_HALT || (op == OP_MVI && pc + 1 == PL)) begin
        q.push_back(mk(0, 0, pc, pc + 1, 1, 0, err, cnt));
        err = err | (op != OP_HALT);
        break;
      end
      q.push_back(mk(1, w, pc, pc + 1, 1, 0, err, cnt));
      pc++;
      l = kl ? 0 : (op == OP_MV || op == OP_MVI) ? 1 : (op == OP_ADD || op == OP_SUB) ? 3 + ext : 0;
      for (int i = 1; i <= WM; i++) begin
        q.push_back(mk(0, rom[pc % 32], pc, pc, 1, 0, err, cnt));
        if (i == l) begin
          cnt = cnt < 255 ? cnt + 1 : 255;
          if (op == OP_MVI) pc++;
          break;
        end
        if (i == WM) begin err = 1; fin = 1; end
      end
      if (SP == 1 && !fin) q.push_back(mk(0, 0, pc, pc, 0, 0, err, cnt));
    end
    for (int i = 0; i < 3; i++) q.push_back(mk(0, 0, pc, pc, 0, 1, err, cnt));
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic load(input logic [8:0] a, input logic [8:0] b, input logic [8:0] c, input logic [8:0] d);
    for (int i = 0; i < 32; i++) rom[i] = '0;
    rom[0] = a; rom[1] = b; rom[2] = c; rom[3] = d;
  endtask

  task automatic pulse_start();
    @(negedge Clock) Start = 1'b1;
    @(posedge Clock) #1 Start = 1'b0;
  endtask

  task automatic wait_q();
    for (int i = 0; i < 300 && q.size() != 0; i++) @(posedge Clock);
    if (q.size() != 0) begin
      checks++; errors++;
      $display("FAIL model_drain: got %0d entries left want 0", q.size());
      q.delete();
    end
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1);
  end

  initial begin
    int b;
    for (int i = 0; i < 32; i++) rom2[i] = '0;
    load(9'o000, 9'o000, 9'o000, 9'o000);
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    chk("rst_run", Run, 0); chk("rst_din", DIN, 0); chk("rst_pc", Pc, 0);
    chk("rst_busy", Busy, 0); chk("rst_halted", Halted, 0); chk("rst_err", Err, 0);
    chk("rst_count", InstrCount, 0);
    Resetn = 1'b1; stray = 1'b1;
    @(negedge Clock) stray = 1'b0;
    @(negedge Clock);
    chk("idle_done_ignored", Busy, 0);

    // mvi R0,#5 then HALT
    load(9'o100, 9'o005, 9'o700, 9'o000);
    b = runs;
    pulse_start(); gen(0, 0); wait_q();
    chk("mvi_run_din", run_din[b % 64], 9'o100);
    chk("mvi_imm_din", nxt_din, 5);
    chk("mvi_pc", Pc, 2); chk("mvi_halted", Halted, 1); chk("mvi_count", InstrCount, 1);
    chk("mvi_runs", runs - b, 1);

    // mv, add, sub, HALT with a Start and a stray Done while busy
    load(9'o010, 9'o201, 9'o301, 9'o700);
    b = runs;
    pulse_start(); gen(0, 0);
    repeat (4) @(posedge Clock);
    #1 Start = 1'b1; stray = 1'b1;
    @(posedge Clock) #1 Start = 1'b0; stray = 1'b0;
    wait_q();
    chk("alu_count", InstrCount, 3); chk("alu_pc", Pc, 3); chk("alu_err", Err, 0);
    chk("alu_runs", runs - b, 3);
    chk("alu_gap_mv", run_cyc[(b + 1) % 64] - run_cyc[b % 64], 3 + SP);
    chk("alu_gap_add", run_cyc[(b + 2) % 64] - run_cyc[(b + 1) % 64], 5 + SP);

    // Done in the watchdog's last cycle wins
    load(9'o201, 9'o700, 9'o000, 9'o000);
    extra = 1;
    pulse_start(); gen(1, 0); wait_q();
    extra = 0;
    chk("late_done_err", Err, 0); chk("late_done_count", InstrCount, 1);

    // Done never arrives for add
    b = runs;
    kill = 1'b1;
    pulse_start(); gen(0, 1); wait_q();
    kill = 1'b0;
    chk("timeout_err", Err, 1); chk("timeout_halted", Halted, 1);
    chk("timeout_runs", runs - b, 1); chk("timeout_count", InstrCount, 0);

    // reset during EXEC of add, then rerun
    load(9'o010, 9'o201, 9'o700, 9'o000);
    b = runs;
    pulse_start();
    for (int i = 0; i < 40 && runs - b < 2; i++) @(negedge Clock);
    chk("reset_reached_add", runs - b, 2);
    Resetn = 1'b0;
    @(negedge Clock) Resetn = 1'b1;
    chk("mid_rst_run", Run, 0); chk("mid_rst_din", DIN, 0); chk("mid_rst_pc", Pc, 0);
    chk("mid_rst_busy", Busy, 0); chk("mid_rst_halted", Halted, 0);
    chk("mid_rst_err", Err, 0); chk("mid_rst_count", InstrCount, 0);
    pulse_start(); gen(0, 0); wait_q();
    chk("rerun_pc", Pc, 2); chk("rerun_count", InstrCount, 2);

    // PROG_LEN=2: truncated mvi, then running off the end
    rom2[0] = 9'o010; rom2[1] = 9'o100;
    b = runs2;
    @(negedge Clock) Start2 = 1'b1;
    @(negedge Clock) Start2 = 1'b0;
    repeat (12) @(negedge Clock);
    chk("trunc_err", Err2, 1); chk("trunc_halted", Halted2, 1); chk("trunc_runs", runs2 - b, 1);
    chk("trunc_count", InstrCount2, 1); chk("trunc_pc", Pc2, 1);
    rom2[1] = 9'o010;
    b = runs2;
    @(negedge Clock) Start2 = 1'b1;
    @(negedge Clock) Start2 = 1'b0;
    repeat (12) @(negedge Clock);
    chk("end_err", Err2, 0); chk("end_halted", Halted2, 1); chk("end_pc", Pc2, 2);
    chk("end_count", InstrCount2, 2); chk("end_runs", runs2 - b, 2);
    chk("end_busy", Busy2, 0); chk("end_din", DIN2, 0);

`ifdef PROC_SEQ_SINGLE_STEP_EN
    Step = 1'b0;
    load(9'o010, 9'o201, 9'o700, 9'o000);
    b = runs;
    pulse_start();
    repeat (6) @(negedge Clock);
    chk("step1_busy", Busy, 0); chk("step1_halted", Halted, 0);
    chk("step1_pc", Pc, 1); chk("step1_runs", runs - b, 1);
    Step = 1'b1;
    @(negedge Clock) Step = 1'b0;
    @(negedge Clock) Start = 1'b1;
    @(negedge Clock) Start = 1'b0;
    repeat (8) @(negedge Clock);
    chk("step2_busy", Busy, 0); chk("step2_pc", Pc, 2);
    chk("step2_count", InstrCount, 2); chk("step2_runs", runs - b, 2);
    Step = 1'b1;
    @(negedge Clock) Step = 1'b0;
    repeat (5) @(negedge Clock);
    chk("step3_halted", Halted, 1); chk("step3_runs", runs - b, 2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
